rr_requester: RTL and testbench

- Requester-side agent for the 4-way round-robin arbiter. One instance sits on each of the arbiter's request/grant line pairs.
- Local logic pushes words into a small FIFO. The agent raises its request line while it holds words that have not yet been granted.
- On each one-cycle grant it drives exactly one word onto the shared bus and pops it.
- It also flags starvation (request pending too long) and protocol errors (grant arriving while empty).

---
 rtl/rr_requester.sv | 151 +++++++++++++++
 tb/tb_rr_requester.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_requester.sv
// Requester-side agent for a 4-way round-robin arbiter: queues local words,
// requests the bus, drives one word per grant, and flags starvation / bad grants.
module rr_requester #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_valid,
    input  logic [DATA_W-1:0]        push_data,
    output logic                     push_ready,
    output logic                     req,
    input  logic                     gnt,
    output logic                     bus_valid,
    output logic [DATA_W-1:0]        bus_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     starve,
    output logic                     err_gnt,
    input  logic                     clr_flags
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] TIMEOUT_C   = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] TIMEOUT_M1  = WAIT_W'(TIMEOUT - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [WAIT_W-1:0] r_wait;
    logic              r_starve;
    logic              r_err_gnt;

    logic              w_push;
    logic              w_pop;
    logic              w_req;
    logic              w_push_ready;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              w_starve_set;
    logic              w_err_set;

    // A grant for the last word drops req in that same cycle so the arbiter
    // never issues a second grant for a word already on the bus.
    assign w_push_ready = (r_count < DEPTH_C);
    assign w_req        = (r_count > {{(CNT_W-1){1'b0}}, gnt});
    assign w_pop        = gnt & (r_count != {CNT_W{1'b0}});
    assign w_push       = push_valid & w_push_ready;
    assign w_err_set    = gnt & (r_count == {CNT_W{1'b0}});

    assign push_ready = w_push_ready;
    assign req        = w_req;
    assign bus_valid  = w_pop;
    assign bus_data   = w_pop ? r_mem[r_rd_ptr] : {DATA_W{1'b0}};
    assign count      = r_count;
    assign starve     = r_starve;
    assign err_gnt    = r_err_gnt;

    // Occupancy next-state from push/pop combination.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Wait counter next-state and starvation set condition.
    always_comb begin
        w_wait_nxt   = {WAIT_W{1'b0}};
        w_starve_set = 1'b0;
        if (w_req && !gnt) begin
            if (r_wait == TIMEOUT_C) begin
                w_wait_nxt = TIMEOUT_C;
            end else begin
                w_wait_nxt = r_wait + WAIT_W'(1);
            end
            w_starve_set = (r_wait == TIMEOUT_M1);
        end else begin
            w_wait_nxt   = {WAIT_W{1'b0}};
            w_starve_set = 1'b0;
        end
    end

    // FIFO storage; cleared on reset so a stale word can never reach the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= {PTR_W{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // Ungranted-request wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= {WAIT_W{1'b0}};
        end else begin
            r_wait <= w_wait_nxt;
        end
    end

    // Sticky flags; a set condition outranks a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve  <= 1'b0;
            r_err_gnt <= 1'b0;
        end else begin
            if (w_starve_set) begin
                r_starve <= 1'b1;
            end else if (clr_flags) begin
                r_starve <= 1'b0;
            end else begin
                r_starve <= r_starve;
            end
            if (w_err_set) begin
                r_err_gnt <= 1'b1;
            end else if (clr_flags) begin
                r_err_gnt <= 1'b0;
            end else begin
                r_err_gnt <= r_err_gnt;
            end
        end
    end

endmodule

// File: tb/tb_rr_requester.sv
// Self-checking bench for rr_requester: vector table, directed corner cases,
// and randomized traffic against a queue-based reference model.
module tb_rr_requester;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              push_valid = 1'b0;
    logic [DATA_W-1:0] push_data = 8'h00;
    logic              push_ready;
    logic              req;
    logic              gnt = 1'b0;
    logic              bus_valid;
    logic [DATA_W-1:0] bus_data;
    logic [2:0]        count;
    logic              starve;
    logic              err_gnt;
    logic              clr_flags = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    rr_requester #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .req        (req),
        .gnt        (gnt),
        .bus_valid  (bus_valid),
        .bus_data   (bus_data),
        .count      (count),
        .starve     (starve),
        .err_gnt    (err_gnt),
        .clr_flags  (clr_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pv;
        logic [7:0] pd;
        logic       g;
        logic       clr;
        int         e_cnt;
        logic       e_req;
        logic       e_pr;
        logic       e_bv;
        logic [7:0] e_bd;
        logic       e_err;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic pv, input logic [7:0] pd, input logic g,
                                input logic clr, input int e_cnt, input logic e_req,
                                input logic e_pr, input logic e_bv, input logic [7:0] e_bd,
                                input logic e_err);
        vec_t v;
        v.pv = pv; v.pd = pd; v.g = g; v.clr = clr; v.e_cnt = e_cnt;
        v.e_req = e_req; v.e_pr = e_pr; v.e_bv = e_bv; v.e_bd = e_bd; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs after the falling edge; outputs settle 1 time unit later.
    task automatic step(input logic pv, input logic [7:0] pd, input logic g, input logic c);
        @(negedge clk);
        push_valid = pv;
        push_data  = pd;
        gnt        = g;
        clr_flags  = c;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        push_valid = 1'b0; gnt = 1'b0; clr_flags = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Reference model state
    logic [7:0] mq[$];
    int         m_wait;
    logic       m_starve, m_err;

    initial begin
        logic [7:0] w[8];
        logic       m_req, m_pop, m_push;
        int         gprob;

        // Reset state, checked while rst_n is held low
        #2 rst_n = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_req", req, 0);
        chk("rst_push_ready", push_ready, 1);
        chk("rst_bus_valid", bus_valid, 0);
        chk("rst_bus_data", bus_data, 0);
        chk("rst_starve", starve, 0);
        chk("rst_err", err_gnt, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        //           pv    pd     g     clr  cnt req  pr   bv   bd     err
        vecs[0]  = mk(1'b1, 8'hA5, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        vecs[1]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        vecs[2]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0);
        vecs[3]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        vecs[4]  = mk(1'b1, 8'h01, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        vecs[5]  = mk(1'b1, 8'h02, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        vecs[6]  = mk(1'b1, 8'h03, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        vecs[7]  = mk(1'b1, 8'h04, 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        vecs[8]  = mk(1'b1, 8'h05, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        vecs[9]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0);
        vecs[10] = mk(1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0);
        vecs[11] = mk(1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0);
        vecs[12] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b1, 8'h04, 1'b0);
        vecs[13] = mk(1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        vecs[14] = mk(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        vecs[15] = mk(1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        vecs[16] = mk(1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        vecs[17] = mk(1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        vecs[18] = mk(1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        vecs[19] = mk(1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].pv, vecs[i].pd, vecs[i].g, vecs[i].clr);
            chk($sformatf("vec%0d_count", i), count, vecs[i].e_cnt);
            chk($sformatf("vec%0d_req", i), req, vecs[i].e_req);
            chk($sformatf("vec%0d_push_ready", i), push_ready, vecs[i].e_pr);
            chk($sformatf("vec%0d_bus_valid", i), bus_valid, vecs[i].e_bv);
            chk($sformatf("vec%0d_bus_data", i), bus_data, vecs[i].e_bd);
            chk($sformatf("vec%0d_err", i), err_gnt, vecs[i].e_err);
            chk($sformatf("vec%0d_starve", i), starve, 0);
        end

        // Starvation: one word, no grants for TIMEOUT edges
        do_reset();
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("stv_req", req, 1);
        for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("stv_not_yet", starve, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("stv_set", starve, 1);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("stv_sticky", starve, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("stv_pre_clr", starve, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("stv_cleared", starve, 0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("stv_bus_valid", bus_valid, 1);
        chk("stv_bus_data", bus_data, 8'h3C);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("stv_count_end", count, 0);
        chk("stv_starve_end", starve, 0);

        // Simultaneous push/pop at count 2 across pointer wrap
        do_reset();
        for (int k = 0; k < 8; k++) w[k] = 8'($urandom);
        step(1'b1, w[0], 1'b0, 1'b0);
        step(1'b1, w[1], 1'b0, 1'b0);
        for (int k = 2; k < 8; k++) begin
            step(1'b1, w[k], 1'b1, 1'b0);
            chk($sformatf("pp%0d_count", k), count, 2);
            chk($sformatf("pp%0d_bus_data", k), bus_data, w[k-2]);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pp_tail0_count", count, 2);
        chk("pp_tail0_data", bus_data, w[6]);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pp_tail1_data", bus_data, w[7]);
        chk("pp_tail1_req", req, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("pp_empty", count, 0);

        // Reset mid-operation
        do_reset();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("mid_count3", count, 3);
        chk("mid_req1", req, 1);
        chk("mid_err1", err_gnt, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", req, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_err", err_gnt, 0);
        chk("mid_rst_starve", starve, 0);
        push_valid = 1'b1; push_data = 8'h77;
        @(negedge clk);
        push_valid = 1'b0;
        #2 rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("mid_post_count", count, 0);
        chk("mid_post_bv", bus_valid, 0);
        chk("mid_post_bd", bus_data, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("mid_post_err", err_gnt, 1);
        chk("mid_post_count2", count, 0);

        // Randomized traffic vs. reference model
        do_reset();
        mq.delete();
        m_wait = 0; m_starve = 1'b0; m_err = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic       pv, g, c;
            logic [7:0] pd;
            logic [7:0] e_bd;
            gprob = (cyc / 500) % 3;
            pv = ($urandom_range(0, 2) != 0);
            pd = 8'($urandom);
            case (gprob)
                0:       g = ($urandom_range(0, 15) == 0);
                1:       g = ($urandom_range(0, 1) == 0);
                default: g = ($urandom_range(0, 7) != 0);
            endcase
            c = ($urandom_range(0, 63) == 0);
            step(pv, pd, g, c);

            m_req  = (mq.size() > int'(g));
            m_pop  = g && (mq.size() != 0);
            m_push = pv && (mq.size() < DEPTH);
            e_bd   = m_pop ? mq[0] : 8'h00;
            chk("rnd_count", count, mq.size());
            chk("rnd_req", req, m_req);
            chk("rnd_push_ready", push_ready, mq.size() < DEPTH);
            chk("rnd_bus_valid", bus_valid, m_pop);
            chk("rnd_bus_data", bus_data, e_bd);
            chk("rnd_starve", starve, m_starve);
            chk("rnd_err", err_gnt, m_err);

            if (g && mq.size() == 0) m_err = 1'b1;
            else if (c)              m_err = 1'b0;
            if (m_req && !g) begin
                if (m_wait == TIMEOUT - 1) m_starve = 1'b1;
                else if (c)                m_starve = 1'b0;
                m_wait = (m_wait < TIMEOUT) ? m_wait + 1 : TIMEOUT;
            end else begin
                if (c) m_starve = 1'b0;
                m_wait = 0;
            end
            if (m_pop)  void'(mq.pop_front());
            if (m_push) mq.push_back(pd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
